// File: rtl/shift_in_word.sv
`default_nettype none
// ============================================================================
// Module      : shift_in_word
// Description : Serial-to-parallel operand collector. After a start request,
//               accepts WIDTH qualified serial bits (x_valid strobe), then
//               presents the word on a held output register with a done flag
//               (fx) that the consumer clears with ack.
//               Optional macro SHIFT_IN_PARITY_EN: one extra even-parity bit
//               is collected after the data bits and checked into parity_err.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_in_word #(
  parameter int WIDTH     = 12,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             x_in,
  input  logic             x_valid,
  input  logic             ack,
  output logic [WIDTH-1:0] x_parallel,
  output logic             fx,
  output logic             busy,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 2);

`ifdef SHIFT_IN_PARITY_EN
  // Data bits followed by one parity bit
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  // Counter value at which the incoming accepted bit is the final one
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] done_word;
  logic             done_perr;

  // Shift register next value with x_in inserted according to bit order
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {shreg[WIDTH-2:0], x_in};
    end else begin : g_lsb_first
      assign shifted = {x_in, shreg[WIDTH-1:1]};
    end
  endgenerate

`ifdef SHIFT_IN_PARITY_EN
  // The final bit is parity: the data is already complete in shreg, and the
  // even-parity check covers the data bits plus the incoming parity bit.
  assign done_word = shreg;
  assign done_perr = ^{shreg, x_in};
`else
  // The final bit is data: the completed word includes it.
  assign done_word = shifted;
  assign done_perr = 1'b0;
`endif

  // Control FSM, shift datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      x_parallel <= '0;
      fx         <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // x_valid and ack have no effect here
          if (start) begin
            state   <= SHIFT;
            shreg   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        SHIFT: begin
          // start aborts the partial word; a bit presented with start is dropped
          if (start) begin
            shreg   <= '0;
            bit_cnt <= '0;
          end else if (x_valid) begin
            if (bit_cnt == LAST_CNT) begin
              x_parallel <= done_word;
              parity_err <= done_perr;
              fx         <= 1'b1;
              busy       <= 1'b0;
              bit_cnt    <= '0;
              state      <= DONE;
            end else begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          // start takes priority over ack; the held word survives until the
          // next completion
          if (start) begin
            state   <= SHIFT;
            shreg   <= '0;
            bit_cnt <= '0;
            fx      <= 1'b0;
            busy    <= 1'b1;
          end else if (ack) begin
            state <= IDLE;
            fx    <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          fx    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_in_word.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_in_word
// Description : Self-checking bench for shift_in_word (WIDTH=12). Runs one
//               MSB-first and one LSB-first instance on shared inputs and
//               compares both against a bit-queue reference model every cycle,
//               plus table vectors and directed corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_in_word;

  localparam int W = 12;
`ifdef SHIFT_IN_PARITY_EN
  localparam int NEED = W + 1;
`else
  localparam int NEED = W;
`endif

  logic clk = 1'b0;
  logic reset, start, x_in, x_valid, ack;
  logic [W-1:0] xpar_m, xpar_l;
  logic fx_m, fx_l, busy_m, busy_l, perr_m, perr_l;

  int n_checks = 0;
  int n_fail   = 0;

  shift_in_word #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .x_valid(x_valid),
    .ack(ack), .x_parallel(xpar_m), .fx(fx_m), .busy(busy_m), .parity_err(perr_m)
  );

  shift_in_word #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .x_valid(x_valid),
    .ack(ack), .x_parallel(xpar_l), .fx(fx_l), .busy(busy_l), .parity_err(perr_l)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = waiting, 1 = collecting, 2 = word ready
  int           m_state = 0;
  bit           m_q[$];
  logic [W-1:0] m_xm = '0, m_xl = '0;
  bit           m_fx = 0, m_perr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_q.delete(); m_xm = '0; m_xl = '0; m_fx = 0; m_perr = 0;
  endtask

  task automatic model_finish();
    bit p;
    p = 0;
    m_xm = '0; m_xl = '0;
    for (int i = 0; i < W; i++) begin
      m_xm[W-1-i] = m_q[i];   // first bit is most significant
      m_xl[i]     = m_q[i];   // first bit is least significant
    end
    foreach (m_q[i]) p = p ^ m_q[i];
    m_perr  = (NEED > W) ? p : 1'b0;
    m_fx    = 1;
    m_state = 2;
  endtask

  task automatic model_step(input logic s, input logic xi, input logic xv, input logic a);
    case (m_state)
      0: if (s) begin m_state = 1; m_q.delete(); end
      1: if (s) m_q.delete();
         else if (xv) begin
           m_q.push_back(xi);
           if (m_q.size() == NEED) model_finish();
         end
      default: if (s) begin m_state = 1; m_fx = 0; m_q.delete(); end
               else if (a) begin m_state = 0; m_fx = 0; end
    endcase
  endtask

  task automatic check_all();
    chk("xpar_m", 32'(xpar_m), 32'(m_xm));
    chk("xpar_l", 32'(xpar_l), 32'(m_xl));
    chk("fx_m",   32'(fx_m),   32'(m_fx));
    chk("fx_l",   32'(fx_l),   32'(m_fx));
    chk("busy_m", 32'(busy_m), 32'(m_state == 1));
    chk("busy_l", 32'(busy_l), 32'(m_state == 1));
    chk("perr_m", 32'(perr_m), 32'(m_perr));
    chk("perr_l", 32'(perr_l), 32'(m_perr));
  endtask

  // One clock cycle: drive inputs, clock, advance model, compare
  task automatic cyc(input logic s, input logic xi, input logic xv, input logic a);
    start = s; x_in = xi; x_valid = xv; ack = a;
    @(posedge clk);
    model_step(s, xi, xv, a);
    #1;
    check_all();
  endtask

  task automatic zeros_now(input string tag);
    chk({tag, "_xm"},  32'(xpar_m), 32'h0);
    chk({tag, "_xl"},  32'(xpar_l), 32'h0);
    chk({tag, "_fx"},  32'(fx_m | fx_l), 32'h0);
    chk({tag, "_bsy"}, 32'(busy_m | busy_l), 32'h0);
    chk({tag, "_per"}, 32'(perr_m | perr_l), 32'h0);
  endtask

  // Assert reset between edges, check outputs clear without a clock edge
  task automatic do_reset();
    start = 0; x_in = 0; x_valid = 0; ack = 0;
    reset = 1;
    model_reset();
    #2;
    zeros_now("async_rst");
    @(posedge clk);
    #1 reset = 0;
  endtask

  // Send 12 data bits (b[11] first), optional 3-cycle gap before bit index gap,
  // then the even-parity bit when parity is enabled
  task automatic send_bits(input logic [11:0] b, input int gap, input bit bad_par);
    for (int i = 0; i < W; i++) begin
      if (gap != 0 && i == gap) begin
        repeat (3) begin
          cyc(0, 0, 0, 0);
          chk("gap_busy", 32'(busy_m & busy_l), 32'h1);
        end
      end
      cyc(0, b[11-i], 1, 0);
    end
`ifdef SHIFT_IN_PARITY_EN
    cyc(0, (^b) ^ bad_par, 1, 0);
`else
    if (bad_par) $display("note: parity disabled, bad_par unused");
`endif
  endtask

  typedef struct {
    logic [11:0] bits;
    int          gap;
    logic [11:0] exp_m;
    logic [11:0] exp_l;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{12'hB0F, 0, 12'hB0F, 12'hF0D};
    vecs[1] = '{12'hB0F, 5, 12'hB0F, 12'hF0D};
    vecs[2] = '{12'h123, 0, 12'h123, 12'hC48};
    vecs[3] = '{12'hFFF, 2, 12'hFFF, 12'hFFF};
    vecs[4] = '{12'h000, 3, 12'h000, 12'h000};
    vecs[5] = '{12'hA5C, 0, 12'hA5C, 12'h3A5};

    reset = 1; start = 0; x_in = 0; x_valid = 0; ack = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    zeros_now("reset_state");

    // Table vectors: complete word, check result, ack, check hold
    for (int v = 0; v < 6; v++) begin
      cyc(1, 0, 0, 0);
      send_bits(vecs[v].bits, vecs[v].gap, 1'b0);
      chk("tbl_xm",   32'(xpar_m), 32'(vecs[v].exp_m));
      chk("tbl_xl",   32'(xpar_l), 32'(vecs[v].exp_l));
      chk("tbl_fx",   32'(fx_m & fx_l), 32'h1);
      chk("tbl_busy", 32'(busy_m | busy_l), 32'h0);
      chk("tbl_perr", 32'(perr_m | perr_l), 32'h0);
      cyc(0, 0, 0, 1);
      chk("ack_fx",   32'(fx_m | fx_l), 32'h0);
      chk("ack_xl",   32'(xpar_l), 32'(vecs[v].exp_l));
    end

    // Restart after 7 bits: no leftover bits; old word held until completion
    cyc(1, 0, 0, 0);
    repeat (7) cyc(0, 1'b1, 1, 0);
    cyc(1, 1, 1, 0);
    chk("rst_hold_xm", 32'(xpar_m), 32'hA5C);
    chk("rst_hold_fx", 32'(fx_m), 32'h0);
    send_bits(12'h123, 0, 1'b0);
    chk("restart_xm", 32'(xpar_m), 32'h123);
    chk("restart_xl", 32'(xpar_l), 32'hC48);

    // start in DONE without ack: fx drops, old word held
    cyc(1, 0, 0, 0);
    chk("done_start_fx", 32'(fx_m), 32'h0);
    chk("done_start_xm", 32'(xpar_m), 32'h123);

    // Reset after 6 bits, then a word of all ones
    repeat (6) cyc(0, 1, 1, 0);
    do_reset();
    cyc(1, 1, 1, 0);  // bit with start is ignored
    send_bits(12'hFFF, 0, 1'b0);
    chk("ones_xm", 32'(xpar_m), 32'hFFF);

    // start+ack together in DONE: start wins
    cyc(1, 0, 0, 1);
    chk("start_ack_fx",   32'(fx_m | fx_l), 32'h0);
    chk("start_ack_busy", 32'(busy_m & busy_l), 32'h1);
    send_bits(12'h0F1, 0, 1'b0);
    chk("par_ok_xm",   32'(xpar_m), 32'h0F1);
    chk("par_ok_perr", 32'(perr_m), 32'h0);
    cyc(1, 0, 0, 1);
    chk("start_ack2_busy", 32'(busy_m), 32'h1);
    send_bits(12'h0F1, 0, 1'b1);
`ifdef SHIFT_IN_PARITY_EN
    chk("par_bad_perr", 32'(perr_m & perr_l), 32'h1);
`else
    chk("par_off_perr", 32'(perr_m | perr_l), 32'h0);
`endif
    cyc(0, 0, 0, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc($urandom_range(0, 29) == 0, 1'($urandom), $urandom_range(0, 9) < 7,
          $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_in_word.md
Name: shift_in_word

Overview:
- Parametrised serial-to-parallel input block: collects WIDTH serial bits after a start request and presents them as a parallel word with a done flag.
- Adds a qualified bit strobe, selectable bit order, a held output register and a consumer acknowledge.
- Feeds operand words into the unsigned multiplier datapath; one instance per operand.
- Fully synchronous to clk; start is a clk-synchronous pulse, not a separate clock edge.

Parameters:
- WIDTH, 12, number of data bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = first received bit lands in x_parallel[WIDTH-1]; 0 = first received bit lands in x_parallel[0].

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  synchronous request to begin collecting a new word; sampled every cycle.
- x_in  input  1  serial data bit.
- x_valid  input  1  qualifies x_in; a bit is taken only on cycles where x_valid=1 in SHIFT.
- ack  input  1  consumer accepted x_parallel; clears fx.
- x_parallel  output  WIDTH  last completed word, held stable until the next word completes.
- fx  output  1  word-ready flag.
- busy  output  1  high while in SHIFT.
- parity_err  output  1  parity result for the last word (see Optional Feature).

Behaviour:
- Reset (async): state=IDLE, shift register=0, bit counter=0, x_parallel=0, fx=0, busy=0, parity_err=0.
- Bit counter width is clog2(WIDTH+2); counts accepted bits only.
- States:
  - IDLE: start=1 -> SHIFT, counter=0, shift register=0.
  - SHIFT: busy=1. Each cycle with x_valid=1, shift in x_in and increment the counter.
    - MSB_FIRST=1: shift left, new bit at bit 0.
    - MSB_FIRST=0: shift right, new bit at bit WIDTH-1.
  - SHIFT -> DONE on the cycle the last required bit is accepted. On that same edge, x_parallel is loaded with the completed word (including that last bit) and fx is set.
  - DONE: fx=1, busy=0. ack=1 -> IDLE with fx=0. start=1 -> SHIFT.
- Latency: fx and the new x_parallel are visible the cycle after the last bit is sampled.
- x_valid=0 in SHIFT: hold; no timeout.
- Simultaneous events:
  - start in the same cycle as the first x_valid: that bit is ignored; collection begins next cycle.
  - start while in SHIFT: abort and restart with counter=0 and shift register=0; x_parallel and fx are unchanged.
  - start and ack together in DONE: start wins; fx=0, state=SHIFT.
  - start in DONE without ack: fx cleared; x_parallel still holds the old word until the new word completes.
- x_valid and ack are ignored in IDLE. ack is ignored in SHIFT.
- x_parallel changes only on word completion or reset; never during shifting.
- Reset asserted mid-word: immediate return to the reset values above; partial data is discarded.

Optional Feature:
- Macro: SHIFT_IN_PARITY_EN.
- Defined:
  - SHIFT collects WIDTH+1 bits; the final bit is an even-parity bit over the WIDTH data bits and is not stored in x_parallel.
  - parity_err is loaded together with x_parallel: 1 if XOR(data bits, parity bit) != 0, else 0.
  - parity_err is held until the next completion or reset.
- Not defined: exactly WIDTH bits collected; parity_err tied to 0.

Test Plan:
- WIDTH=12, MSB_FIRST=1: start, then 12 valid bits 1,0,1,1,0,0,0,0,1,1,1,1 -> x_parallel=12'hB0F, fx=1 one cycle after the 12th bit, busy=0.
- Same bits with MSB_FIRST=0 -> x_parallel=12'hF0D; ack pulse -> fx=0, x_parallel still 12'hF0D.
- Idle cycles (x_valid=0) inserted between bits 5 and 6 -> same result 12'hB0F; busy stays 1 throughout the gap.
- Restart: after 7 bits, start again, then send 12 bits of 12'h123 -> x_parallel=12'h123 (no leftover bits); previous x_parallel and fx unchanged until completion.
- Reset after 6 bits -> all outputs 0 immediately. A following start plus 12 ones -> x_parallel=12'hFFF.
- SHIFT_IN_PARITY_EN defined: word 12'h0F1 with parity 1 -> parity_err=0. Same word with parity 0 -> parity_err=1. Both must also cover start+ack in the same DONE cycle -> fx=0, busy=1.
